// File: rtl/pd0_apb_pkg.sv
// pd0_apb_pkg
//   Shared definitions for the PD0 APB initiator:
//   - apb_mst_state_e : transfer FSM states (IDLE, SETUP, ACCESS, RESP)
//   - DEF_* widths    : default address/data widths and timeout
//   - APB_ALIGN_MASK  : byte-offset bits that must be zero for a word access
//   - is_aligned()    : word-alignment test on the low address bits
//   - wait_cnt_width(): width of the ACCESS wait counter for a given timeout
package pd0_apb_pkg;

    localparam int unsigned DEF_ADDR_WIDTH     = 32;
    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    localparam logic [1:0] APB_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return ((addr_lsb & APB_ALIGN_MASK) == 2'b00);
    endfunction

    // A timeout of 0 disables the abort, but the counter still needs one bit.
    function automatic int unsigned wait_cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer
//   Counts ACCESS cycles spent with PREADY low and flags when the configured
//   limit has been reached. The count saturates instead of wrapping.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clr        : zero the count (start of a new transfer)
//     en         : add one wait cycle
//     expired    : count has reached TIMEOUT_CYCLES (never set when 0)
module apb_wait_timer
    import pd0_apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = wait_cnt_width(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // With the timeout disabled the counter simply parks at all-ones.
    localparam logic [CNT_W-1:0] CNT_SAT =
        (TIMEOUT_CYCLES == 0) ? {CNT_W{1'b1}} : CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_SAT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (count == CNT_SAT);

endmodule

// File: rtl/pd0_apb_master.sv
// pd0_apb_master
//   APB3 initiator for the PD0 bus. Accepts one valid/ready command at a
//   time, runs a SETUP/ACCESS transfer, and returns a valid/ready response.
//   Misaligned commands are answered with an error without touching the bus;
//   transfers stalled longer than TIMEOUT_CYCLES are aborted.
//   Ports:
//     PCLK, PRESETn                 : clock, asynchronous active-low reset
//     cmd_valid/ready/write/addr/wdata : command channel
//     rsp_valid/ready/rdata/err/timeout : response channel
//     PADDR, PWRITE, PSEL, PENABLE, PWDATA : APB master outputs
//     PRDATA, PREADY, PSLVERR              : APB master inputs
//   Every output is a flop; outputs are loaded from the next-state decode so
//   they change in the same cycle as the state register.
module pd0_apb_master
    import pd0_apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    // command channel
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // APB master port
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_mst_state_e state, next_state;

    logic                  latch_cmd;
    logic                  rsp_load;
    logic                  rsp_err_d;
    logic                  rsp_timeout_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_d;
    logic                  timer_clr;
    logic                  timer_en;
    logic                  timer_expired;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .clr    (timer_clr),
        .en     (timer_en),
        .expired(timer_expired)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        latch_cmd     = 1'b0;
        rsp_load      = 1'b0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = '0;
        timer_clr     = 1'b0;
        timer_en      = 1'b0;

        case (state)
            IDLE: begin
                // cmd_ready is high exactly while in IDLE.
                if (cmd_valid) begin
                    if (is_aligned(cmd_addr[1:0])) begin
                        latch_cmd  = 1'b1;
                        timer_clr  = 1'b1;
                        next_state = SETUP;
                    end else begin
                        rsp_load   = 1'b1;
                        rsp_err_d  = 1'b1;
                        next_state = RESP;
                    end
                end
            end

            SETUP: begin
                next_state = ACCESS;
            end

            ACCESS: begin
                // A ready slave wins over a timeout expiring in the same cycle.
                if (PREADY) begin
                    rsp_load    = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = (PWRITE || PSLVERR) ? '0 : PRDATA;
                    next_state  = RESP;
                end else if (timer_expired) begin
                    rsp_load      = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    next_state    = RESP;
                end else begin
                    timer_en = 1'b1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Handshake and bus-qualifier flops follow the next state.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
        end else begin
            cmd_ready <= (next_state == IDLE);
            rsp_valid <= (next_state == RESP);
            PSEL      <= (next_state == SETUP) || (next_state == ACCESS);
            PENABLE   <= (next_state == ACCESS);
        end
    end

    // Address/data hold their last values between transfers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else if (latch_cmd) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_wdata;
        end
    end

    // Response fields are loaded once on entry to RESP and then held.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (rsp_load) begin
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_pd0_apb_master.sv
module tb_pd0_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    pd0_apb_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK       (clk),
        .PRESETn    (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR      (paddr),
        .PWRITE     (pwrite),
        .PSEL       (psel),
        .PENABLE    (penable),
        .PWDATA     (pwdata),
        .PRDATA     (prdata),
        .PREADY     (pready),
        .PSLVERR    (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;     // ACCESS cycles with PREADY low (>=60: never ready)
        logic [DW-1:0] prdata;
        logic          pslverr;
        int            hold;      // cycles rsp_ready stays low once rsp_valid rises
        int            exp_lat;   // cycle of rsp_valid, accept cycle = 0
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic          exp_to;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   lat;
        logic bus_ok;
        logic stable_ok;
        logic aligned;
        v       = vecs[idx];
        aligned = (v.addr[1:0] == 2'b00);
        check($sformatf("v%0d_cmd_ready", idx), 32'(cmd_ready), 32'd1);

        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        rsp_ready = (v.hold == 0);
        prdata    = v.prdata;
        pslverr   = v.pslverr;
        lat       = -1;
        bus_ok    = 1'b1;

        for (int c = 0; c < 60; c++) begin
            if (c > 0 && rsp_valid) begin
                lat = c;
                if (psel || penable) bus_ok = 1'b0;
                break;
            end
            if (c > 0) begin
                if (psel !== aligned) bus_ok = 1'b0;
                if (penable !== (aligned && c >= 2)) bus_ok = 1'b0;
                if (c == 1 && aligned) begin
                    check($sformatf("v%0d_paddr", idx), paddr, v.addr);
                    check($sformatf("v%0d_pwrite", idx), 32'(pwrite), 32'(v.write));
                    check($sformatf("v%0d_pwdata", idx), pwdata, v.wdata);
                end
            end
            pready = (c >= 2 + v.waits);
            tick();
            cmd_valid = 1'b0;
        end
        pready = 1'b0;

        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        check($sformatf("v%0d_bus_seq", idx), 32'(bus_ok), 32'd1);
        check($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d_err", idx), 32'(rsp_err), 32'(v.exp_err));
        check($sformatf("v%0d_timeout", idx), 32'(rsp_timeout), 32'(v.exp_to));

        stable_ok = 1'b1;
        for (int h = 0; h < v.hold; h++) begin
            if (!rsp_valid || rsp_rdata !== v.exp_rdata || rsp_err !== v.exp_err ||
                rsp_timeout !== v.exp_to || cmd_ready || psel || penable)
                stable_ok = 1'b0;
            tick();
        end
        if (v.hold > 0)
            check($sformatf("v%0d_hold_stable", idx), 32'(stable_ok), 32'd1);

        rsp_ready = 1'b1;
        tick();
        check($sformatf("v%0d_idle_after", idx), {30'd0, cmd_ready, rsp_valid}, 32'b10);
    endtask

    task automatic reset_mid_access();
        logic quiet;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_0050;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b1;
        pready    = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("rst_pre_access", {30'd0, psel, penable}, 32'b11);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_bus", {30'd0, psel, penable}, 32'b00);
        check("rst_async_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        quiet = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid || psel || penable || !cmd_ready) quiet = 1'b0;
            tick();
        end
        check("rst_no_response", 32'(quiet), 32'd1);
    endtask

    initial begin
        //           wr    addr          wdata         waits prdata        slverr hold lat rdata         err   to
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_1234, 0,  32'h1111_1111, 1'b0, 0, 3,  32'h0000_0000, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 3,  32'hDEAD_BEEF, 1'b0, 0, 6,  32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 99, 32'h7777_7777, 1'b0, 0, 11, 32'h0000_0000, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 32'h0000_0003, 32'h5555_AAAA, 0,  32'h0000_0000, 1'b0, 0, 1,  32'h0000_0000, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_000C, 32'h0000_0000, 0,  32'h1234_5678, 1'b1, 5, 3,  32'h0000_0000, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 8,  32'hCAFE_F00D, 1'b0, 0, 11, 32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 32'h0000_0022, 32'h0000_0000, 0,  32'h0BAD_0BAD, 1'b0, 0, 1,  32'h0000_0000, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 7,  32'h0F0F_F0F0, 1'b0, 0, 10, 32'h0F0F_F0F0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 32'h0000_0040, 32'h3C3C_C3C3, 1,  32'h9999_9999, 1'b0, 0, 4,  32'h0000_0000, 1'b0, 1'b0};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset_ctrl", {28'd0, rsp_valid, psel, penable, pwrite}, 32'd0);
        check("reset_paddr", paddr, 32'd0);
        check("reset_pwdata", pwdata, 32'd0);
        check("reset_rsp", {rsp_rdata[29:0], rsp_err, rsp_timeout}, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            if (i == 8) reset_mid_access();
            run_vec(i);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pd0_apb_master.md
# pd0_apb_master

APB3 initiator for the PD0 subsystem: drives the master-side port of the PD0 APB bus (PADDR_M … PSLVERR_M) on behalf of a simple valid/ready command/response client (host bridge, debug port or boot sequencer). It performs one outstanding transfer at a time using SETUP/ACCESS phases, tolerates slave wait states, flags misaligned accesses and aborts hung transfers with a timeout. It sits in the main `clk` domain next to the APB bus fabric.

## Interface
- ADDR_WIDTH, 32: PADDR and command address width.
- DATA_WIDTH, 32: PWDATA/PRDATA width.
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.
- PCLK  in  1  bus clock (subsystem `clk`).
- PRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  client accepts the response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  PSLVERR, misalignment or timeout.
- rsp_timeout  out  1  error cause was a timeout.
- PADDR, PWRITE, PSEL, PENABLE, PWDATA  out  ADDR_WIDTH/1/1/1/DATA_WIDTH  APB master outputs.
- PRDATA, PREADY, PSLVERR  in  DATA_WIDTH/1/1  APB master inputs.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch write, addr and wdata.
  - Aligned address (addr[1:0]==0) → SETUP.
  - Misaligned address → RESP with rsp_err=1 and rsp_timeout=0. No bus cycle is issued.
- SETUP: PSEL=1, PENABLE=0, with PADDR/PWRITE/PWDATA from the latch → ACCESS unconditionally.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: capture PRDATA (reads only) and PSLVERR → RESP.
  - PREADY=0: increment the wait counter. If TIMEOUT_CYCLES≠0 and the count reaches TIMEOUT_CYCLES → RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- RESP: PSEL=0, PENABLE=0, rsp_valid=1. Response fields stay stable until rsp_valid&rsp_ready → IDLE.
- PADDR/PWRITE/PWDATA keep their last values outside transfers. Only PSEL/PENABLE are qualified.
- The wait counter clears on entry to SETUP. Its width is $clog2(TIMEOUT_CYCLES+1), minimum 1, and it saturates rather than wrapping.
- A slave that asserts PREADY in the same cycle the timeout would fire completes normally; PREADY has priority.
- PSLVERR is sampled only when PREADY=1 in ACCESS.

## Timing
- Reset values: all outputs 0 except cmd_ready=1. FSM=IDLE, counter=0.
- Reset asserted mid-transfer: PSEL/PENABLE drop immediately (asynchronous) and no response is produced for the aborted command.
- Zero-wait transfer: accept at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, rsp_valid at cycle 3.
- Each wait state adds one cycle.
- Misaligned command: rsp_valid at cycle 1.
- Back-to-back: after the response handshake at cycle N, the next command can be accepted at N+1. Minimum issue interval is 4 cycles with rsp_ready held high.
- Timeout: rsp_valid appears exactly TIMEOUT_CYCLES+1 cycles after the first ACCESS cycle.
- All outputs are registered; there is no combinational path from PREADY or PRDATA to any output.

## Structure
- Package `pd0_apb_pkg`:
  - State enum `apb_mst_state_e` {IDLE, SETUP, ACCESS, RESP}.
  - Default width constants.
  - Constant `APB_ALIGN_MASK = 2'b11`.
- Sub-module `apb_wait_timer`: wait counter with clear, enable, saturate and `expired` output; parameterised by TIMEOUT_CYCLES.

## Test plan
- Write 0x0000_0010 ← 0xA5A5_1234 to a zero-wait slave → PSEL high cycles 1-2, PENABLE high cycle 2, PWDATA=0xA5A5_1234, rsp_valid cycle 3, rsp_err=0.
- Read 0x0000_0004 with 3 wait states, PRDATA=0xDEAD_BEEF → rsp_valid at cycle 6, rsp_rdata=0xDEAD_BEEF.
- TIMEOUT_CYCLES=8, PREADY held low → abort after 8 ACCESS cycles, rsp_err=1, rsp_timeout=1, PSEL=0 in RESP.
- Command addr 0x0000_0003 → no PSEL assertion, rsp_valid cycle 1, rsp_err=1, rsp_timeout=0.
- Slave returns PSLVERR=1 with PREADY → rsp_err=1, rsp_timeout=0. rsp_ready held low for 5 cycles → response stable and cmd_ready=0 throughout.
- PRESETn pulsed low during ACCESS → PSEL/PENABLE=0 asynchronously, cmd_ready=1 after release, no rsp_valid; the next command completes normally.
